// File: rtl/popcount_byte_feeder.sv
`default_nettype none
// ============================================================================
// Module      : popcount_byte_feeder
// Description : Upstream feeder for the byte popcount unit. Deserialises an
//               MSB-first serial stream into words, buffers one complete word,
//               runs the start/load/done handshake with the popcount unit and
//               returns each count as a one-cycle valid result. Sticky flags
//               report dropped words (overrun) and aborted waits (timeout).
// Ports       : i_clk/i_rst      clock, synchronous active-high reset
//               i_sdata/i_svalid serial bit in (MSB first) and its qualifier
//               i_clr            clears the sticky o_overrun / o_timeout
//               o_start/o_load   handshake strobes to the popcount unit
//               o_data           word presented to the popcount unit
//               i_done/i_sum     completion level and count from the unit
//               o_result(_valid) last captured count and its update pulse
//               o_busy           FSM is not idle
//               o_overrun        sticky: a complete word was dropped
//               o_timeout        sticky: wait for done was aborted
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_byte_feeder #(
    parameter int DATA_W  = 8,
    parameter int SUM_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sdata,
    input  logic              i_svalid,
    input  logic              i_clr,
    output logic              o_start,
    output logic              o_load,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_done,
    input  logic [SUM_W-1:0]  i_sum,
    output logic [SUM_W-1:0]  o_result,
    output logic              o_result_valid,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_timeout
);

    localparam int c_CNT_W = $clog2(DATA_W);
    localparam int c_TMR_W = $clog2(TIMEOUT);

    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;

    logic [2:0]         r_state;
    logic [DATA_W-2:0]  r_shift;      // MSB of the word is never needed again
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0]  r_hold;
    logic               r_hold_full;
    logic [DATA_W-1:0]  r_data;
    logic [SUM_W-1:0]   r_result;
    logic               r_ok;
    logic               r_done_d;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_overrun;
    logic               r_timeout;

    logic [DATA_W-1:0]  w_next_word;
    logic               w_byte_done;
    logic               w_hold_accept;
    logic               w_done_rise;
    logic               w_timeout_evt;

    assign w_next_word   = {r_shift, i_sdata};
    assign w_byte_done   = i_svalid && (r_bit_cnt == c_LAST_BIT);
    // The hold register may be refilled in the same cycle it drains (LOAD).
    assign w_hold_accept = w_byte_done && (!r_hold_full || (r_state == S_LOAD));
    // Only a fresh 0->1 edge while waiting counts; a stale high level does not.
    assign w_done_rise   = i_done && !r_done_d;
    assign w_timeout_evt = (r_state == S_WAIT) && !w_done_rise && (r_timer == c_TMR_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_data      <= '0;
            r_result    <= '0;
            r_ok        <= 1'b0;
            r_done_d    <= 1'b0;
            r_timer     <= '0;
            r_overrun   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_done_d <= i_done;

            // Deserialiser
            if (i_svalid) begin
                r_shift <= w_next_word[DATA_W-2:0];
                if (w_byte_done) begin
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                end
            end

            // One-word holding buffer
            if (w_hold_accept) begin
                r_hold      <= w_next_word;
                r_hold_full <= 1'b1;
            end else if (r_state == S_LOAD) begin
                r_hold_full <= 1'b0;
            end

            // Sticky error flags: a new event has priority over clear
            if (w_byte_done && !w_hold_accept) begin
                r_overrun <= 1'b1;
            end else if (i_clr) begin
                r_overrun <= 1'b0;
            end

            if (w_timeout_evt) begin
                r_timeout <= 1'b1;
            end else if (i_clr) begin
                r_timeout <= 1'b0;
            end

            // Handshake FSM
            case (r_state)
                S_IDLE: begin
                    if (r_hold_full) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_data  <= r_hold;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_rise) begin
                        r_result <= i_sum;
                        r_ok     <= 1'b1;
                        r_state  <= S_ACK;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_ok    <= 1'b0;
                        r_state <= S_ACK;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode: strobes depend only on the state register.
    // o_start fires in START and again in ACK to release the popcount unit.
    assign o_start        = (r_state == S_START) || (r_state == S_ACK);
    assign o_load         = (r_state == S_LOAD);
    assign o_busy         = (r_state != S_IDLE);
    assign o_result_valid = (r_state == S_ACK) && r_ok;
    assign o_data         = r_data;
    assign o_result       = r_result;
    assign o_overrun      = r_overrun;
    assign o_timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_popcount_byte_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_byte_feeder
// Description : Self-checking bench for popcount_byte_feeder. A popcount stub
//               answers the handshake; expected words and counts are queued
//               when bytes are sent and compared when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_byte_feeder;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_sdata = 1'b0;
    logic       i_svalid = 1'b0;
    logic       i_clr = 1'b0;
    logic       i_done = 1'b0;
    logic [3:0] i_sum = 4'd0;
    logic       o_start, o_load, o_result_valid, o_busy, o_overrun, o_timeout;
    logic [7:0] o_data;
    logic [3:0] o_result;

    int checks = 0;
    int errors = 0;

    logic [7:0] data_q[$];
    logic [3:0] res_q[$];

    // stub control: 0 auto-answer, 1 never answer, 2 manual levels
    int         stub_mode  = 0;
    int         stub_delay = 3;
    int         stub_cnt   = 0;
    bit         stub_armed = 1'b0;
    logic [7:0] stub_data  = 8'd0;
    logic       man_done   = 1'b0;
    logic [3:0] man_sum    = 4'd0;
    logic       rv_prev    = 1'b0;

    always #5 clk = ~clk;

    popcount_byte_feeder #(.DATA_W(8), .SUM_W(4), .TIMEOUT(64)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_sdata(i_sdata), .i_svalid(i_svalid),
        .i_clr(i_clr), .o_start(o_start), .o_load(o_load), .o_data(o_data),
        .i_done(i_done), .i_sum(i_sum), .o_result(o_result),
        .o_result_valid(o_result_valid), .o_busy(o_busy),
        .o_overrun(o_overrun), .o_timeout(o_timeout)
    );

    function automatic logic [3:0] pc(input logic [7:0] b);
        int n = 0;
        for (int k = 0; k < 8; k++) n += int'(b[k]);
        return 4'(n);
    endfunction

    // popcount unit stub
    always @(negedge clk) begin
        case (stub_mode)
            0: begin
                if (o_start) i_done = 1'b0;
                if (o_load) begin
                    stub_data  = o_data;
                    stub_cnt   = stub_delay;
                    stub_armed = 1'b1;
                end else if (stub_armed) begin
                    if (stub_cnt > 1) begin
                        stub_cnt--;
                    end else begin
                        i_done     = 1'b1;
                        i_sum      = pc(stub_data);
                        stub_armed = 1'b0;
                    end
                end
            end
            1: begin
                i_done     = 1'b0;
                stub_armed = 1'b0;
            end
            default: begin
                i_done     = man_done;
                i_sum      = man_sum;
                stub_armed = 1'b0;
            end
        endcase
    end

    // scoreboard: words at o_load, counts at o_result_valid
    always @(negedge clk) begin
        if (!i_rst) begin
            if (o_load) begin
                checks++;
                if (data_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_data: unexpected load, o_data=%h", o_data);
                end else if (o_data !== data_q[0]) begin
                    errors++;
                    $display("FAIL load_data: got %h expected %h", o_data, data_q[0]);
                    void'(data_q.pop_front());
                end else begin
                    void'(data_q.pop_front());
                end
            end
            if (o_result_valid) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL result: unexpected valid, o_result=%0d", o_result);
                end else if (o_result !== res_q[0]) begin
                    errors++;
                    $display("FAIL result: got %0d expected %0d", o_result, res_q[0]);
                    void'(res_q.pop_front());
                end else begin
                    void'(res_q.pop_front());
                end
                if (rv_prev) begin
                    errors++;
                    $display("FAIL valid_pulse: valid high 2 cycles, got 1 expected 0");
                end
            end
        end
        rv_prev = o_result_valid;
    end

    task automatic send_byte(input logic [7:0] b, input bit expect_it);
        if (expect_it) begin
            data_q.push_back(b);
            res_q.push_back(pc(b));
        end
        for (int i = 7; i >= 0; i--) begin
            i_sdata  = b[i];
            i_svalid = 1'b1;
            @(negedge clk);
        end
        i_svalid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        repeat (3) @(negedge clk);
        while ((o_busy || res_q.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_busy || res_q.size() != 0) begin
            errors++;
            $display("FAIL idle_wait: busy=%b pending=%0d expected busy=0 pending=0",
                     o_busy, res_q.size());
        end
    endtask

    task automatic wait_load(input int max);
        int n = 0;
        while (!o_load && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!o_load) begin
            errors++;
            $display("FAIL load_wait: o_load=%b expected 1", o_load);
        end
    endtask

    task automatic test_reset();
        logic [17:0] outs;
        repeat (3) @(negedge clk);
        outs = {o_start, o_load, o_data, o_result, o_result_valid, o_busy, o_overrun, o_timeout};
        checks++;
        if (outs !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        i_rst = 1'b0;
        // partial byte, then reset mid-stream while bits keep arriving
        for (int i = 0; i < 3; i++) begin
            i_sdata = 1'b1; i_svalid = 1'b1;
            @(negedge clk);
        end
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_svalid = 1'b0;
        outs = {o_start, o_load, o_data, o_result, o_result_valid, o_busy, o_overrun, o_timeout};
        checks++;
        if (outs !== 18'd0) begin
            errors++;
            $display("FAIL reset_midstream: got %h expected 0", outs);
        end
        i_rst = 1'b0;
        send_byte(8'h81, 1'b1);
        wait_idle(100);
    endtask

    task automatic test_single();
        send_byte(8'hB2, 1'b1);
        checks++;
        if (o_start !== 1'b0) begin
            errors++;
            $display("FAIL start_latency_early: o_start=%b expected 0", o_start);
        end
        @(negedge clk);
        checks++;
        if (o_start !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: start=%b busy=%b expected 1 1", o_start, o_busy);
        end
        @(negedge clk);
        checks++;
        if (o_load !== 1'b1 || o_start !== 1'b0) begin
            errors++;
            $display("FAIL load_after_start: load=%b start=%b expected 1 0", o_load, o_start);
        end
        wait_idle(100);
        checks++;
        if (o_result !== 4'd4) begin
            errors++;
            $display("FAIL single_result_hold: got %0d expected 4", o_result);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'hB2, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_idle(200);
        checks++;
        if (o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: got %b expected 0", o_overrun);
        end
    endtask

    task automatic test_overrun();
        stub_delay = 40;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        wait_idle(400);
        checks++;
        if (o_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b expected 1", o_overrun);
        end
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        checks++;
        if (o_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 0", o_overrun);
        end
        stub_delay = 3;
    endtask

    task automatic test_stale_done();
        man_sum   = 4'd7;
        man_done  = 1'b1;
        stub_mode = 2;
        @(negedge clk);
        send_byte(8'h3C, 1'b1);
        wait_load(50);
        repeat (6) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1 || o_result !== 4'd2) begin
            errors++;
            $display("FAIL stale_no_capture: busy=%b result=%0d expected 1 2", o_busy, o_result);
        end
        man_done = 1'b0;
        repeat (2) @(negedge clk);
        man_sum  = 4'd4;
        man_done = 1'b1;
        wait_idle(100);
        man_done  = 1'b0;
        @(negedge clk);
        stub_mode = 0;
    endtask

    task automatic test_timeout();
        stub_mode = 1;
        data_q.push_back(8'hAA);
        send_byte(8'hAA, 1'b0);
        wait_load(50);
        for (int i = 1; i <= 65; i++) begin
            @(negedge clk);
            if (i == 64) begin
                checks++;
                if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_early: timeout=%b busy=%b expected 0 1", o_timeout, o_busy);
                end
            end
        end
        checks++;
        if (o_timeout !== 1'b1 || o_start !== 1'b1 || o_result_valid !== 1'b0 || o_result !== 4'd4) begin
            errors++;
            $display("FAIL timeout_ack: timeout=%b start=%b valid=%b result=%0d expected 1 1 0 4",
                     o_timeout, o_start, o_result_valid, o_result);
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b expected 0", o_busy);
        end
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        checks++;
        if (o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b expected 0", o_timeout);
        end
        stub_mode = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_stale_done();
        test_timeout();
        checks++;
        if (data_q.size() != 0) begin
            errors++;
            $display("FAIL load_pending: %0d words never loaded, expected 0", data_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
